// File: rtl/rv32_mod_bus_responder_ram.sv
// Word RAM responder on the req/ack/err bus, with fixed wait states.
// Ports: clk, reset (async, active low), req/wr/be/addr/data_i in; ack/err/data_o out.
module rv32_mod_bus_responder_ram #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] data_i,
  output logic        ack,
  output logic        err,
  output logic [31:0] data_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // 33-bit bounds so a window ending at 2^32 does not wrap
  localparam logic [32:0] LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] HI = LO + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [AW-1:0] idx_q;
  logic          fault_q;

  logic          accept;
  logic          fault_in;
  logic [AW-1:0] idx_in;
  logic [32:0]   addr_x;

  logic [31:0] mem [DEPTH_WORDS];

  assign addr_x   = {1'b0, addr};
  assign fault_in = (addr[1:0] != 2'b00)
                 || (addr_x < LO)
                 || (addr_x >= HI);
  assign idx_in   = AW'((addr - ADDR_BASE) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    data_o  = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = WS_LOAD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (fault_q) begin
          err = 1'b1;
        end else begin
          ack = 1'b1;
          if (!wr_q) begin
            data_o = mem[idx_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'h0;
      idx_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= wr;
        be_q    <= be;
        wdata_q <= data_i;
        idx_q   <= idx_in;
        fault_q <= fault_in;
      end
    end
  end

  // Write commits on the edge leaving RESP; an async reset
  // during RESP clears state_q first, so nothing is written.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q && !fault_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_rv32_mod_bus_responder_ram.sv
// Directed bench for rv32_mod_bus_responder_ram.
// Four instances cover wait-state, base-address and reset cases.
module tb_rv32_mod_bus_responder_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req  [4];
  logic        wr   [4];
  logic [3:0]  be   [4];
  logic [31:0] addr [4];
  logic [31:0] wdat [4];
  logic        ack  [4];
  logic        err  [4];
  logic [31:0] rdat [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv32_mod_bus_responder_ram #(
    .ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(0)
  ) u_ws0 (
    .clk(clk), .reset(rst_n), .req(req[0]), .wr(wr[0]),
    .be(be[0]), .addr(addr[0]), .data_i(wdat[0]),
    .ack(ack[0]), .err(err[0]), .data_o(rdat[0])
  );

  rv32_mod_bus_responder_ram #(
    .ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(3)
  ) u_ws3 (
    .clk(clk), .reset(rst_n), .req(req[1]), .wr(wr[1]),
    .be(be[1]), .addr(addr[1]), .data_i(wdat[1]),
    .ack(ack[1]), .err(err[1]), .data_o(rdat[1])
  );

  rv32_mod_bus_responder_ram #(
    .ADDR_BASE(32'h1000_0000), .DEPTH_WORDS(1024), .WAIT_STATES(0)
  ) u_flt (
    .clk(clk), .reset(rst_n), .req(req[2]), .wr(wr[2]),
    .be(be[2]), .addr(addr[2]), .data_i(wdat[2]),
    .ack(ack[2]), .err(err[2]), .data_o(rdat[2])
  );

  rv32_mod_bus_responder_ram #(
    .ADDR_BASE(32'h0), .DEPTH_WORDS(1024), .WAIT_STATES(5)
  ) u_ws5 (
    .clk(clk), .reset(rst_n), .req(req[3]), .wr(wr[3]),
    .be(be[3]), .addr(addr[3]), .data_i(wdat[3]),
    .ack(ack[3]), .err(err[3]), .data_o(rdat[3])
  );

  // Drives one request and waits for its response (bounded).
  // lat is the cycle count from request to response, -1 on timeout.
  task automatic access(input int u, input logic w,
                        input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d, output int lat,
                        output logic ak, output logic er,
                        output logic [31:0] q);
    req[u] = 1'b1; wr[u] = w; be[u] = b; addr[u] = a; wdat[u] = d;
    lat = -1; ak = 1'b0; er = 1'b0; q = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[u] || err[u]) begin
        lat = c; ak = ack[u]; er = err[u]; q = rdat[u];
        break;
      end
    end
    req[u] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (ack[u] !== 1'b0 || err[u] !== 1'b0 || rdat[u] !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs u=%0d got ack=%b err=%b data=%h exp 0 0 0",
                 u, ack[u], err[u], rdat[u]);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic ak, er; logic [31:0] q;
    access(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, ak, er, q);
    checks++;
    if (lat !== 1 || ak !== 1'b1 || er !== 1'b0 || q !== 32'h0) begin
      errors++;
      $display("FAIL t1_write got lat=%0d ack=%b err=%b data=%h exp 1 1 0 0",
               lat, ak, er, q);
    end
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, ak, er, q);
    checks++;
    if (lat !== 1 || ak !== 1'b1 || er !== 1'b0 || q !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_read got lat=%0d ack=%b err=%b data=%h exp 1 1 0 deadbeef",
               lat, ak, er, q);
    end
  endtask

  task automatic test_partial();
    int lat; logic ak, er; logic [31:0] q;
    access(0, 1'b1, 4'b0001, 32'h10, 32'h000000AA, lat, ak, er, q);
    access(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || q !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL t2_partial got ack=%b data=%h exp 1 deadbeaa", ak, q);
    end
    access(0, 1'b1, 4'b1100, 32'h10, 32'h1234_0000, lat, ak, er, q);
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, ak, er, q);
    checks++;
    if (q !== 32'h1234BEAA) begin
      errors++;
      $display("FAIL t2_upper_half got data=%h exp 1234beaa", q);
    end
    access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL t2_be0_ack got ack=%b err=%b exp 1 0", ak, er);
    end
    access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, ak, er, q);
    checks++;
    if (q !== 32'h1234BEAA) begin
      errors++;
      $display("FAIL t2_be0_nochange got data=%h exp 1234beaa", q);
    end
  endtask

  task automatic test_wait_states();
    int lat; logic ak, er; logic [31:0] q;
    int hits[$];
    int bad;
    access(1, 1'b1, 4'hF, 32'h10, 32'hA5A5_0F0F, lat, ak, er, q);
    checks++;
    if (lat !== 4 || ak !== 1'b1) begin
      errors++;
      $display("FAIL t3_write_lat got lat=%0d ack=%b exp 4 1", lat, ak);
    end
    access(1, 1'b0, 4'h0, 32'h10, 32'h0, lat, ak, er, q);
    checks++;
    if (lat !== 4 || ak !== 1'b1 || q !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL t3_read got lat=%0d ack=%b data=%h exp 4 1 a5a50f0f",
               lat, ak, q);
    end
    bad = 0;
    req[1] = 1'b1; wr[1] = 1'b0; be[1] = 4'h0; addr[1] = 32'h10;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ack[1]) hits.push_back(c);
      if (err[1]) bad++;
      if (hits.size() == 3) break;
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (hits.size() != 3) begin
      errors++;
      $display("FAIL t3_b2b_count got %0d acks exp 3", hits.size());
    end else if (hits[0] != 4 || hits[1] != 9 || hits[2] != 14) begin
      errors++;
      $display("FAIL t3_b2b_spacing got %0d %0d %0d exp 4 9 14",
               hits[0], hits[1], hits[2]);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL t3_b2b_err got %0d err pulses exp 0", bad);
    end
  endtask

  task automatic test_faults();
    int lat; logic ak, er; logic [31:0] q;
    access(2, 1'b1, 4'hF, 32'h1000_0000, 32'h1111_1111, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0) begin
      errors++;
      $display("FAIL t4_base_write got ack=%b err=%b exp 1 0", ak, er);
    end
    access(2, 1'b0, 4'h0, 32'h1000_0002, 32'h0, lat, ak, er, q);
    checks++;
    if (lat !== 1 || ak !== 1'b0 || er !== 1'b1 || q !== 32'h0) begin
      errors++;
      $display("FAIL t4_misalign got lat=%0d ack=%b err=%b data=%h exp 1 0 1 0",
               lat, ak, er, q);
    end
    access(2, 1'b1, 4'hF, 32'h1000_1000, 32'h2222_2222, lat, ak, er, q);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1) begin
      errors++;
      $display("FAIL t4_above got ack=%b err=%b exp 0 1", ak, er);
    end
    access(2, 1'b0, 4'h0, 32'h1000_0000, 32'h0, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || q !== 32'h1111_1111) begin
      errors++;
      $display("FAIL t4_unchanged got ack=%b data=%h exp 1 11111111", ak, q);
    end
    access(2, 1'b0, 4'h0, 32'h0FFF_FFFC, 32'h0, lat, ak, er, q);
    checks++;
    if (ak !== 1'b0 || er !== 1'b1 || q !== 32'h0) begin
      errors++;
      $display("FAIL t4_below got ack=%b err=%b data=%h exp 0 1 0", ak, er, q);
    end
    access(2, 1'b1, 4'hF, 32'h1000_0FFC, 32'hCAFE_F00D, lat, ak, er, q);
    access(2, 1'b0, 4'h0, 32'h1000_0FFC, 32'h0, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || er !== 1'b0 || q !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL t4_top_word got ack=%b err=%b data=%h exp 1 0 cafef00d",
               ak, er, q);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic ak, er; logic [31:0] q;
    int seen;
    access(3, 1'b1, 4'hF, 32'h20, 32'hAAAA_5555, lat, ak, er, q);
    checks++;
    if (lat !== 6 || ak !== 1'b1) begin
      errors++;
      $display("FAIL t5_prewrite got lat=%0d ack=%b exp 6 1", lat, ak);
    end
    req[3] = 1'b1; wr[3] = 1'b1; be[3] = 4'hF;
    addr[3] = 32'h20; wdat[3] = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ack[3] !== 1'b0 || err[3] !== 1'b0 || rdat[3] !== 32'h0) begin
      errors++;
      $display("FAIL t5_busy_reset got ack=%b err=%b data=%h exp 0 0 0",
               ack[3], err[3], rdat[3]);
    end
    req[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ack[3] || err[3]) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL t5_no_resp got %0d responses exp 0", seen);
    end
    access(3, 1'b0, 4'h0, 32'h20, 32'h0, lat, ak, er, q);
    checks++;
    if (lat !== 6 || ak !== 1'b1 || q !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL t5_old_data got lat=%0d ack=%b data=%h exp 6 1 aaaa5555",
               lat, ak, q);
    end
    // Reset landing in the RESP cycle itself must also drop the write.
    access(3, 1'b1, 4'hF, 32'h24, 32'h0BAD_F00D, lat, ak, er, q);
    req[3] = 1'b1; wr[3] = 1'b1; be[3] = 4'hF;
    addr[3] = 32'h24; wdat[3] = 32'h7777_7777;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[3]) begin
        seen = c;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (seen != 6 || ack[3] !== 1'b0) begin
      errors++;
      $display("FAIL t5_resp_reset got ack_cycle=%0d ack=%b exp 6 0",
               seen, ack[3]);
    end
    req[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(3, 1'b0, 4'h0, 32'h24, 32'h0, lat, ak, er, q);
    checks++;
    if (ak !== 1'b1 || q !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL t5_resp_nowrite got ack=%b data=%h exp 1 0badf00d", ak, q);
    end
  endtask

  task automatic test_input_change();
    int lat; logic ak, er; logic [31:0] q;
    access(1, 1'b1, 4'hF, 32'h44, 32'h0000_0055, lat, ak, er, q);
    req[1] = 1'b1; wr[1] = 1'b1; be[1] = 4'hF;
    addr[1] = 32'h40; wdat[1] = 32'h0102_0304;
    @(posedge clk); #1;
    addr[1] = 32'h44; wdat[1] = 32'hFFFF_FFFF; wr[1] = 1'b0;
    lat = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack[1] || err[1]) begin
        lat = c;
        break;
      end
    end
    req[1] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL t6_latency got %0d exp 4", lat);
    end
    access(1, 1'b0, 4'h0, 32'h40, 32'h0, lat, ak, er, q);
    checks++;
    if (q !== 32'h0102_0304) begin
      errors++;
      $display("FAIL t6_latched_word got data=%h exp 01020304", q);
    end
    access(1, 1'b0, 4'h0, 32'h44, 32'h0, lat, ak, er, q);
    checks++;
    if (q !== 32'h0000_0055) begin
      errors++;
      $display("FAIL t6_other_word got data=%h exp 00000055", q);
    end
  endtask

  initial begin
    for (int u = 0; u < 4; u++) begin
      req[u] = 1'b0; wr[u] = 1'b0; be[u] = 4'h0;
      addr[u] = 32'h0; wdat[u] = 32'h0;
    end
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_partial();
    test_wait_states();
    test_faults();
    test_reset_mid();
    test_input_change();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
